// File: rtl/pkt_tx_arbiter_if.sv
// rtl/pkt_tx_arbiter_if.sv - source beat and MAC pkt_tx signal bundle for pkt_tx_arbiter
// Signals:
//   src0_*/src1_* : data[63:0], sop, eop, mod[2:0], val (source -> arbiter); rdy (arbiter -> source)
//   pkt_tx_*      : data[63:0], sop, eop, mod[2:0], val (arbiter -> MAC); full (MAC -> arbiter)
// Modports: master = arbiter side, slave = sources/MAC side.
interface pkt_tx_arbiter_if;
   logic [63:0] src0_data;
   logic        src0_sop;
   logic        src0_eop;
   logic [2:0]  src0_mod;
   logic        src0_val;
   logic        src0_rdy;
   logic [63:0] src1_data;
   logic        src1_sop;
   logic        src1_eop;
   logic [2:0]  src1_mod;
   logic        src1_val;
   logic        src1_rdy;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_sop;
   logic        pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic        pkt_tx_val;
   logic        pkt_tx_full;

   modport master (
      input  src0_data, src0_sop, src0_eop, src0_mod, src0_val,
      output src0_rdy,
      input  src1_data, src1_sop, src1_eop, src1_mod, src1_val,
      output src1_rdy,
      output pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val,
      input  pkt_tx_full
   );

   modport slave (
      output src0_data, src0_sop, src0_eop, src0_mod, src0_val,
      input  src0_rdy,
      output src1_data, src1_sop, src1_eop, src1_mod, src1_val,
      input  src1_rdy,
      input  pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val,
      output pkt_tx_full
   );
endinterface

// File: rtl/pkt_tx_arbiter.sv
// rtl/pkt_tx_arbiter.sv - packet-granular two-source round-robin arbiter for the MAC TX packet interface
// Ports:
//   clk_156, async_reset_n : clock and asynchronous active-low reset
//   bus (master)           : source beats/rdy and registered MAC pkt_tx_* outputs, pkt_tx_full input
//   grant[1:0]             : registered one-hot owner (01 = src0, 10 = src1, 00 = idle)
//   srcN_pkt_cnt           : packets forwarded from source N
//   srcN_drop_cnt          : beats discarded from source N
//   wdog_err               : sticky beats-per-packet watchdog flag
// Optional feature macro: PKT_TX_ARB_STATS_EN (statistics counters; outputs tie to 0 when undefined).
module pkt_tx_arbiter #(
   parameter int CNT_W     = 32,
   parameter int MAX_BEATS = 1200
) (
   input  logic             clk_156,
   input  logic             async_reset_n,
   pkt_tx_arbiter_if.master bus,
   output logic [1:0]       grant,
   output logic [CNT_W-1:0] src0_pkt_cnt,
   output logic [CNT_W-1:0] src1_pkt_cnt,
   output logic [CNT_W-1:0] src0_drop_cnt,
   output logic [CNT_W-1:0] src1_drop_cnt,
   output logic             wdog_err
);
   localparam int            BW      = $clog2(MAX_BEATS + 1);
   localparam logic [BW-1:0] WD_LAST = BW'(MAX_BEATS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   state_t        state_q;
   logic          last_q;
   logic [BW-1:0] beat_cnt_q;
   logic [1:0]    grant_q;
   logic          wdog_q;
   logic [63:0]   data_q;
   logic          sop_q;
   logic          eop_q;
   logic [2:0]    mod_q;
   logic          val_q;

   logic          rdy0_d, rdy1_d;
   logic          own_val, own_sop, own_eop;
   logic [63:0]   own_data;
   logic [2:0]    own_mod;
   logic          own_acc, first_beat, wd_hit;
   logic          req0, req1;
   logic [1:0]    drop_d;
   logic [1:0]    pkt_done_d;

   // The owner sees MAC backpressure; a non-owner is only ever offered
   // acceptance for non-sop beats, which are strays to be discarded.
   always_comb begin
      rdy0_d = !bus.src0_sop;
      rdy1_d = !bus.src1_sop;
      if (state_q == OWN0) rdy0_d = !bus.pkt_tx_full;
      if (state_q == OWN1) rdy1_d = !bus.pkt_tx_full;
   end

   assign bus.src0_rdy = rdy0_d;
   assign bus.src1_rdy = rdy1_d;

   always_comb begin
      own_val  = 1'b0;
      own_sop  = bus.src0_sop;
      own_eop  = bus.src0_eop;
      own_data = bus.src0_data;
      own_mod  = bus.src0_mod;
      if (state_q == OWN0) begin
         own_val = bus.src0_val;
      end else if (state_q == OWN1) begin
         own_val  = bus.src1_val;
         own_sop  = bus.src1_sop;
         own_eop  = bus.src1_eop;
         own_data = bus.src1_data;
         own_mod  = bus.src1_mod;
      end
   end

   assign own_acc    = own_val && !bus.pkt_tx_full;
   assign first_beat = (beat_cnt_q == '0);
   assign wd_hit     = own_acc && !own_eop && (beat_cnt_q == WD_LAST);
   assign req0       = bus.src0_val && bus.src0_sop;
   assign req1       = bus.src1_val && bus.src1_sop;

   // A drop is either a discarded stray beat or a repeated sop inside an owned packet.
   assign drop_d[0] = (state_q != OWN0) ? (bus.src0_val && rdy0_d)
                                        : (own_acc && own_sop && !first_beat);
   assign drop_d[1] = (state_q != OWN1) ? (bus.src1_val && rdy1_d)
                                        : (own_acc && own_sop && !first_beat);
   assign pkt_done_d[0] = (state_q == OWN0) && own_acc && own_eop;
   assign pkt_done_d[1] = (state_q == OWN1) && own_acc && own_eop;

   always_ff @(posedge clk_156 or negedge async_reset_n) begin
      if (!async_reset_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         beat_cnt_q <= '0;
         grant_q    <= 2'b00;
         wdog_q     <= 1'b0;
         data_q     <= '0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         mod_q      <= 3'd0;
         val_q      <= 1'b0;
      end else begin
         val_q <= own_acc;
         if (own_acc) begin
            data_q <= own_data;
            sop_q  <= own_sop && first_beat;
            eop_q  <= own_eop || wd_hit;
            mod_q  <= wd_hit ? 3'd0 : own_mod;
         end
         case (state_q)
            IDLE: begin
               beat_cnt_q <= '0;
               // On a tie the source that did not finish the last packet wins.
               if (req0 && (!req1 || last_q)) begin
                  state_q <= OWN0;
                  grant_q <= 2'b01;
               end else if (req1) begin
                  state_q <= OWN1;
                  grant_q <= 2'b10;
               end
            end
            OWN0, OWN1: begin
               if (own_acc) begin
                  if (own_eop || wd_hit) begin
                     state_q    <= IDLE;
                     grant_q    <= 2'b00;
                     last_q     <= (state_q == OWN1);
                     beat_cnt_q <= '0;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + BW'(1);
                  end
                  if (wd_hit) wdog_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   assign bus.pkt_tx_data = data_q;
   assign bus.pkt_tx_sop  = sop_q;
   assign bus.pkt_tx_eop  = eop_q;
   assign bus.pkt_tx_mod  = mod_q;
   assign bus.pkt_tx_val  = val_q;
   assign grant           = grant_q;
   assign wdog_err        = wdog_q;

`ifdef PKT_TX_ARB_STATS_EN
   logic [CNT_W-1:0] pkt0_q, pkt1_q, drop0_q, drop1_q;

   always_ff @(posedge clk_156 or negedge async_reset_n) begin
      if (!async_reset_n) begin
         pkt0_q  <= '0;
         pkt1_q  <= '0;
         drop0_q <= '0;
         drop1_q <= '0;
      end else begin
         if (pkt_done_d[0]) pkt0_q  <= pkt0_q + CNT_W'(1);
         if (pkt_done_d[1]) pkt1_q  <= pkt1_q + CNT_W'(1);
         if (drop_d[0])     drop0_q <= drop0_q + CNT_W'(1);
         if (drop_d[1])     drop1_q <= drop1_q + CNT_W'(1);
      end
   end

   assign src0_pkt_cnt  = pkt0_q;
   assign src1_pkt_cnt  = pkt1_q;
   assign src0_drop_cnt = drop0_q;
   assign src1_drop_cnt = drop1_q;
`else
   logic unused_stats;
   assign unused_stats  = ^{drop_d, pkt_done_d};
   assign src0_pkt_cnt  = '0;
   assign src1_pkt_cnt  = '0;
   assign src0_drop_cnt = '0;
   assign src1_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// tb/tb_pkt_tx_arbiter.sv - scoreboard testbench for pkt_tx_arbiter
module tb_pkt_tx_arbiter;
   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
   } beat_t;

`ifdef PKT_TX_ARB_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic        clk_156 = 1'b0;
   logic        async_reset_n;
   logic [1:0]  grant;
   logic [31:0] src0_pkt_cnt, src1_pkt_cnt, src0_drop_cnt, src1_drop_cnt;
   logic        wdog_err;

   pkt_tx_arbiter_if bus();

   pkt_tx_arbiter #(.CNT_W(32), .MAX_BEATS(8)) dut (
      .clk_156       (clk_156),
      .async_reset_n (async_reset_n),
      .bus           (bus),
      .grant         (grant),
      .src0_pkt_cnt  (src0_pkt_cnt),
      .src1_pkt_cnt  (src1_pkt_cnt),
      .src0_drop_cnt (src0_drop_cnt),
      .src1_drop_cnt (src1_drop_cnt),
      .wdog_err      (wdog_err)
   );

   always #5 clk_156 = ~clk_156;

   beat_t q0[$];
   beat_t q1[$];
   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    sent0 = 0, sent1 = 0;
   int    exp_pkt0 = 0, exp_pkt1 = 0, exp_drop0 = 0, exp_drop1 = 0;

   function automatic beat_t mk(input int s, input int p, input int i,
                                input logic sop, input logic eop, input logic [2:0] mod);
      beat_t b;
      b.data = {4'(s), 28'd0, 16'(p), 16'(i)};
      b.sop  = sop;
      b.eop  = eop;
      b.mod  = mod;
      return b;
   endfunction

   function automatic logic [31:0] stat(input int v);
      return STATS_EN ? 32'(v) : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_cnt(input string name);
      chk({name, "_src0_pkt_cnt"},  64'(src0_pkt_cnt),  64'(stat(exp_pkt0)));
      chk({name, "_src1_pkt_cnt"},  64'(src1_pkt_cnt),  64'(stat(exp_pkt1)));
      chk({name, "_src0_drop_cnt"}, 64'(src0_drop_cnt), 64'(stat(exp_drop0)));
      chk({name, "_src1_drop_cnt"}, 64'(src1_drop_cnt), 64'(stat(exp_drop1)));
   endtask

   task automatic drive(input int s, input beat_t b, input logic v);
      if (s == 0) begin
         bus.src0_data = b.data; bus.src0_sop = b.sop; bus.src0_eop = b.eop;
         bus.src0_mod  = b.mod;  bus.src0_val = v;
      end else begin
         bus.src1_data = b.data; bus.src1_sop = b.sop; bus.src1_eop = b.eop;
         bus.src1_mod  = b.mod;  bus.src1_val = v;
      end
   endtask

   // Presents the head of the source queue and retires it once val && rdy was seen.
   task automatic run_driver(input int s);
      logic acc;
      forever begin
         @(negedge clk_156);
         acc = (s == 0) ? (bus.src0_val && bus.src0_rdy) : (bus.src1_val && bus.src1_rdy);
         @(posedge clk_156);
         #1;
         if (s == 0) begin
            if (acc && q0.size() > 0) begin void'(q0.pop_front()); sent0++; end
            if (q0.size() > 0) drive(0, q0[0], 1'b1); else drive(0, '0, 1'b0);
         end else begin
            if (acc && q1.size() > 0) begin void'(q1.pop_front()); sent1++; end
            if (q1.size() > 0) drive(1, q1[0], 1'b1); else drive(1, '0, 1'b0);
         end
      end
   endtask

   initial run_driver(0);
   initial run_driver(1);

   // Monitor: every MAC-side beat must match the head of the expected queue.
   always @(negedge clk_156) begin
      if (bus.pkt_tx_val === 1'b1) begin
         beat_t a, e;
         a = {bus.pkt_tx_data, bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pkt_tx_unexpected actual data=%0h sop=%0b eop=%0b mod=%0d required none",
                     a.data, a.sop, a.eop, a.mod);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL pkt_tx_beat actual data=%0h sop=%0b eop=%0b mod=%0d required data=%0h sop=%0b eop=%0b mod=%0d",
                        a.data, a.sop, a.eop, a.mod, e.data, e.sop, e.eop, e.mod);
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 ||
              bus.src0_val || bus.src1_val) && n < 300) begin
         @(negedge clk_156);
         n++;
      end
      repeat (2) @(negedge clk_156);
      chk({name, "_drain_timeout"}, 64'(n >= 300), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_val"},  64'(bus.pkt_tx_val),  64'd0);
      chk({name, "_sop"},  64'(bus.pkt_tx_sop),  64'd0);
      chk({name, "_eop"},  64'(bus.pkt_tx_eop),  64'd0);
      chk({name, "_mod"},  64'(bus.pkt_tx_mod),  64'd0);
      chk({name, "_data"}, bus.pkt_tx_data,      64'd0);
      chk({name, "_grant"}, 64'(grant),          64'd0);
      chk({name, "_wdog"},  64'(wdog_err),       64'd0);
      chk_cnt(name);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      int base;
      drive(0, '0, 1'b0);
      drive(1, '0, 1'b0);
      bus.pkt_tx_full = 1'b0;
      async_reset_n = 1'b0;
      repeat (3) @(negedge clk_156);
      chk_reset_outputs("reset");
      async_reset_n = 1'b1;
      @(negedge clk_156);

      // Tie round-robin: last resets to 1, so src0 wins first.
      for (int p = 0; p < 2; p++) begin
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 2; i++) begin
               if (s == 0) q0.push_back(mk(0, p, i, i == 0, i == 1, 3'(i + 2)));
               else        q1.push_back(mk(1, p, i, i == 0, i == 1, 3'(i + 2)));
               exp_q.push_back(mk(s, p, i, i == 0, i == 1, 3'(i + 2)));
            end
         end
      end
      wait_idle("tie");
      exp_pkt0 += 2; exp_pkt1 += 2;
      chk_cnt("tie");

      // Single 4-beat src0 packet, mod=5 on every beat.
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk(0, 16, i, i == 0, i == 3, 3'd5));
         exp_q.push_back(mk(0, 16, i, i == 0, i == 3, 3'd5));
      end
      n = 0;
      while (grant == 2'b00 && n < 20) begin @(negedge clk_156); n++; end
      chk("single_grant_own", 64'(grant), 64'b01);
      wait_idle("single");
      chk("single_grant_idle", 64'(grant), 64'b00);
      exp_pkt0 += 1;
      chk_cnt("single");

      // Backpressure: 6-beat src1 packet, full for 3 cycles after beat 2 is accepted.
      for (int i = 0; i < 6; i++) begin
         q1.push_back(mk(1, 32, i, i == 0, i == 5, 3'(i)));
         exp_q.push_back(mk(1, 32, i, i == 0, i == 5, 3'(i)));
      end
      base = sent1;
      n = 0;
      while (sent1 < base + 3 && n < 50) begin @(posedge clk_156); #2; n++; end
      chk("bp_reach_beat2_timeout", 64'(n >= 50), 64'd0);
      bus.pkt_tx_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_156);
         chk("bp_src1_rdy", 64'(bus.src1_rdy), 64'd0);
         if (i > 0) chk("bp_no_val", 64'(bus.pkt_tx_val), 64'd0);
         @(posedge clk_156);
         #1;
      end
      bus.pkt_tx_full = 1'b0;
      @(negedge clk_156);
      chk("bp_no_val", 64'(bus.pkt_tx_val), 64'd0);
      wait_idle("bp");
      exp_pkt1 += 1;
      chk_cnt("bp");

      // Repeated sop mid-packet: forwarded with sop=0, counted as one drop.
      q1.push_back(mk(1, 48, 0, 1'b1, 1'b0, 3'd0));
      q1.push_back(mk(1, 48, 1, 1'b1, 1'b0, 3'd1));
      q1.push_back(mk(1, 48, 2, 1'b0, 1'b1, 3'd3));
      exp_q.push_back(mk(1, 48, 0, 1'b1, 1'b0, 3'd0));
      exp_q.push_back(mk(1, 48, 1, 1'b0, 1'b0, 3'd1));
      exp_q.push_back(mk(1, 48, 2, 1'b0, 1'b1, 3'd3));
      wait_idle("sop_err");
      exp_pkt1 += 1; exp_drop1 += 1;
      chk_cnt("sop_err");

      // Stray src1 beat while src0 owns the interface.
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk(0, 64, i, i == 0, i == 3, 3'd7));
         exp_q.push_back(mk(0, 64, i, i == 0, i == 3, 3'd7));
      end
      n = 0;
      while (grant != 2'b01 && n < 20) begin @(negedge clk_156); n++; end
      chk("stray_grant", 64'(grant), 64'b01);
      q1.push_back(mk(1, 65, 0, 1'b0, 1'b0, 3'd2));
      n = 0;
      while (bus.src1_val !== 1'b1 && n < 20) begin @(negedge clk_156); n++; end
      chk("stray_src1_rdy", 64'(bus.src1_rdy), 64'd1);
      wait_idle("stray");
      exp_pkt0 += 1; exp_drop1 += 1;
      chk_cnt("stray");

      // Watchdog at 8 beats: beat index 7 closes the packet, the last two are strays.
      chk("wdog_before", 64'(wdog_err), 64'd0);
      for (int i = 0; i < 10; i++) begin
         q0.push_back(mk(0, 80, i, i == 0, 1'b0, 3'd6));
         if (i < 7)       exp_q.push_back(mk(0, 80, i, i == 0, 1'b0, 3'd6));
         else if (i == 7) exp_q.push_back(mk(0, 80, i, 1'b0, 1'b1, 3'd0));
      end
      wait_idle("wdog");
      chk("wdog_after", 64'(wdog_err), 64'd1);
      exp_drop0 += 2;
      chk_cnt("wdog");

      // Reset asserted while beat 2 of a 5-beat src0 packet is presented.
      for (int i = 0; i < 5; i++) begin
         q0.push_back(mk(0, 96, i, i == 0, i == 4, 3'd1));
         exp_q.push_back(mk(0, 96, i, i == 0, i == 4, 3'd1));
      end
      base = sent0;
      n = 0;
      while (sent0 < base + 2 && n < 50) begin @(posedge clk_156); #2; n++; end
      chk("rst_reach_beat2_timeout", 64'(n >= 50), 64'd0);
      async_reset_n = 1'b0;
      q0.delete();
      exp_q.delete();
      exp_pkt0 = 0; exp_pkt1 = 0; exp_drop0 = 0; exp_drop1 = 0;
      #1;
      chk_reset_outputs("midrst");
      repeat (2) @(negedge clk_156);
      async_reset_n = 1'b1;
      repeat (2) @(negedge clk_156);

      // After reset a tie must again go to src0 first.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 2; i++) begin
            if (s == 0) q0.push_back(mk(0, 112, i, i == 0, i == 1, 3'd4));
            else        q1.push_back(mk(1, 112, i, i == 0, i == 1, 3'd4));
            exp_q.push_back(mk(s, 112, i, i == 0, i == 1, 3'd4));
         end
      end
      wait_idle("post_rst");
      exp_pkt0 += 1; exp_pkt1 += 1;
      chk_cnt("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
